// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter that shares one FIFO
// write port among NREQ valid/ready/last requesters.
// A grant is taken in IDLE and held until the granted requester's last beat
// has been written; the round-robin pointer then moves just past the winner.
// Optional build macro FIFO_ARB_TAG_EN: prefixes each written beat with the
// binary index of the granted requester (fifo_wdata = {idx, data}).
module fifo_wr_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int IW   = $clog2(NREQ),
`ifdef FIFO_ARB_TAG_EN
  localparam int FW   = IW + DW
`else
  localparam int FW   = DW
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [FW-1:0]      fifo_wdata,
  output logic               fifo_wen,
  input  logic               fifo_wfull
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;
  logic [IW-1:0]     rr_ptr_q;

  logic [IW-1:0]     win_idx;
  logic              win_found;
  logic [IW-1:0]     gnt_idx;
  logic [DW-1:0]     gnt_data;
  logic [NREQ-1:0]   acc_vec;
  logic              pkt_end;
  logic [IW-1:0]     rr_next;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int j;
    j         = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // Decode the one-hot grant into an index and select that requester's data.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        gnt_idx  = gnt_idx | IW'(i);
        gnt_data = gnt_data | req_data[i*DW +: DW];
      end
    end
  end

  // Ready depends only on the registered grant and the FIFO full flag, so
  // there is no combinational loop from a requester's valid to its ready.
  assign req_ready = (state_q == GRANT && !fifo_wfull) ? grant_q : '0;
  assign acc_vec   = req_valid & req_ready;
  assign fifo_wen  = |acc_vec;
  assign pkt_end   = |(acc_vec & req_last);
  assign rr_next   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);

  // grant is zero in IDLE, so both the index and the data slice read as zero.
`ifdef FIFO_ARB_TAG_EN
  assign fifo_wdata = {gnt_idx, gnt_data};
`else
  assign fifo_wdata = gnt_data;
`endif

  assign grant = grant_q;
  assign busy  = busy_q;

  // Arbitration FSM: take a grant in IDLE, release it after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q <= NREQ'(1) << win_idx;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (pkt_end) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_next;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NREQ=4, DW=8). Per-requester beat buffers
// feed a driver; expected FIFO writes go into a scoreboard queue that a
// negedge monitor drains whenever fifo_wen is high.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;
`ifdef FIFO_ARB_TAG_EN
  localparam int FW   = IW + DW;
`else
  localparam int FW   = DW;
`endif

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [FW-1:0]      fifo_wdata;
  logic               fifo_wen;
  logic               fifo_wfull;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_wfull(fifo_wfull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-requester beat buffers: {last, data}
  logic [DW:0]     mem [NREQ][64];
  int              wr_p [NREQ];
  int              rd_p [NREQ];
  logic [NREQ-1:0] drv_acc;

  task automatic push_beat(input int r, input logic [DW-1:0] d, input logic l);
    mem[r][wr_p[r]] = {l, d};
    wr_p[r]++;
  endtask

  // Scoreboard of expected FIFO writes
  typedef struct {
    logic [FW-1:0] wd;
    int            idx;
    int            gap;
  } exp_t;
  exp_t sb_q[$];
  int   last_wr_cyc = 0;

  task automatic exp_push(input int r, input logic [DW-1:0] d, input int gap);
    exp_t e;
`ifdef FIFO_ARB_TAG_EN
    e.wd = {IW'(r), d};
`else
    e.wd = d;
`endif
    e.idx = r;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Driver: after each edge, retire accepted beats and present the next ones.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end
    forever begin
      @(negedge clk);
      drv_acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (drv_acc[i]) rd_p[i]++;
        if (rd_p[i] != wr_p[i]) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = mem[i][rd_p[i]][DW-1:0];
          req_last[i]           = mem[i][rd_p[i]][DW];
        end else begin
          req_valid[i]          = 1'b0;
          req_data[i*DW +: DW]  = '0;
          req_last[i]           = 1'b0;
        end
      end
    end
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h expected=none (cycle %0d)", fifo_wdata, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("wr_data", 32'(fifo_wdata), 32'(e.wd));
          chk("wr_grant", 32'(grant), 32'(1) << e.idx);
          if (e.gap != 0) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'(e.gap));
        end
        last_wr_cyc = cyc;
      end
    end
  end

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (rd_p[i] != wr_p[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || pending()) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    fifo_wfull = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wen", 32'(fifo_wen), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_rr", 32'(dut.rr_ptr_q), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // No requests for 5 cycles
    repeat (5) begin
      @(negedge clk);
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_wen", 32'(fifo_wen), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Requesters 1 and 2, three beats each; one bubble between packets
    @(posedge clk);
    #1;
    push_beat(1, 8'h11, 1'b0); push_beat(1, 8'h12, 1'b0); push_beat(1, 8'h13, 1'b1);
    push_beat(2, 8'h21, 1'b0); push_beat(2, 8'h22, 1'b0); push_beat(2, 8'h23, 1'b1);
    exp_push(1, 8'h11, 0); exp_push(1, 8'h12, 1); exp_push(1, 8'h13, 1);
    exp_push(2, 8'h21, 2); exp_push(2, 8'h22, 1); exp_push(2, 8'h23, 1);
    drain("two_pkts");
    chk("two_pkts_rr", 32'(dut.rr_ptr_q), 32'd3);

    // All four requesters with single-beat packets: rotation 0,1,2,3,0,...
    do_reset();
    chk("rr_after_reset", 32'(dut.rr_ptr_q), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      push_beat(i, 8'hB0 | 8'(i), 1'b1);
      push_beat(i, 8'hC0 | 8'(i), 1'b1);
    end
    for (int i = 0; i < NREQ; i++) exp_push(i, 8'hB0 | 8'(i), (i == 0) ? 0 : 2);
    for (int i = 0; i < NREQ; i++) exp_push(i, 8'hC0 | 8'(i), 2);
    drain("rotate");
    chk("rotate_rr", 32'(dut.rr_ptr_q), 32'd0);

    // FIFO full for 4 cycles in the middle of requester 3's packet
    @(posedge clk);
    #1;
    push_beat(3, 8'hA0, 1'b0); push_beat(3, 8'hA1, 1'b0);
    push_beat(3, 8'hA2, 1'b0); push_beat(3, 8'hA3, 1'b1);
    exp_push(3, 8'hA0, 0); exp_push(3, 8'hA1, 1);
    exp_push(3, 8'hA2, 5); exp_push(3, 8'hA3, 1);
    repeat (3) @(posedge clk);
    #1 fifo_wfull = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_wen", 32'(fifo_wen), 32'd0);
      chk("stall_grant", 32'(grant), 32'b1000);
    end
    @(posedge clk);
    #1 fifo_wfull = 1'b0;
    drain("stall");

    // Requester 0 goes quiet mid-packet; requester 2 must wait
    @(posedge clk);
    #1;
    push_beat(0, 8'h01, 1'b0); push_beat(0, 8'h02, 1'b0);
    push_beat(2, 8'h2A, 1'b1);
    exp_push(0, 8'h01, 0); exp_push(0, 8'h02, 1);
    exp_push(0, 8'h03, 4); exp_push(2, 8'h2A, 2);
    repeat (3) @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("gap_grant", 32'(grant), 32'b0001);
      chk("gap_wen", 32'(fifo_wen), 32'd0);
    end
    @(posedge clk);
    #1 push_beat(0, 8'h03, 1'b1);
    drain("gap");
    chk("gap_rr", 32'(dut.rr_ptr_q), 32'd3);

`ifdef FIFO_ARB_TAG_EN
    // Tagged beat from requester 2
    @(posedge clk);
    #1;
    push_beat(2, 8'h5C, 1'b1);
    exp_push(2, 8'h5C, 0);
    @(posedge clk);
    @(negedge clk);
    chk("tag_wdata", 32'(fifo_wdata), 32'h25C);
    drain("tag");
`endif

    // Reset in the middle of requester 1's packet
    @(posedge clk);
    #1;
    push_beat(1, 8'h71, 1'b0); push_beat(1, 8'h72, 1'b0); push_beat(1, 8'h73, 1'b1);
    exp_push(1, 8'h71, 0); exp_push(1, 8'h72, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rr", 32'(dut.rr_ptr_q), 32'd0);
    chk("midrst_wen", 32'(fifo_wen), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rd_p[1] = wr_p[1];
    drain("midrst");
    @(negedge clk);
    chk("midrst_after_grant", 32'(grant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, packet-locked arbiter that shares the write port of an `AsyncFifo` instance among `NREQ` requesters in the FIFO's write clock domain. Each requester presents a valid/ready/last stream. The arbiter grants one requester at a time and holds the grant until that requester's `last` beat is written. Its output drives `wdata`/`wen` of the FIFO and consumes the FIFO's `wfull` flag.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `DW`, 8: payload width per requester.
- `IW`, derived `$clog2(NREQ)`: requester index width, localparam.

Ports:
- `clk`, in, 1: single clock; the FIFO's `wclk`.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NREQ: bit i = requester i has a beat.
- `req_data`, in, NREQ*DW: requester i occupies bits `[i*DW +: DW]`.
- `req_last`, in, NREQ: bit i = current beat of requester i ends its packet.
- `req_ready`, out, NREQ: bit i = beat of requester i is accepted this cycle when valid.
- `grant`, out, NREQ: one-hot registered grant; all zero in IDLE.
- `busy`, out, 1: state is GRANT.
- `fifo_wdata`, out, FW: to the FIFO `wdata`. FW = DW, or IW+DW with `FIFO_ARB_TAG_EN`.
- `fifo_wen`, out, 1: to the FIFO `wen`.
- `fifo_wfull`, in, 1: from the FIFO `wfull`.

## Operation
- The state machine has two states: IDLE and GRANT.
- IDLE:
  - If `|req_valid`, pick the winner by searching from `rr_ptr` upward, modulo NREQ, for the first set `req_valid` bit.
  - Register the one-hot `grant` for the winner and go to GRANT.
  - Nothing is written in IDLE.
- GRANT:
  - `req_ready[i] = grant[i] & ~fifo_wfull`. All other ready bits are 0.
  - A beat is accepted when `req_valid[i] & req_ready[i]` for the granted i.
  - On acceptance, `fifo_wen = 1` and `fifo_wdata` = the granted requester's data slice.
  - Otherwise `fifo_wen = 0`, and `fifo_wdata` still carries the granted slice.
- Packet end: when an accepted beat has `req_last[i] = 1`, the block updates three things at the next edge:
  - `grant` goes to 0.
  - State goes to IDLE.
  - `rr_ptr` becomes (i+1) mod NREQ.
- Gaps: if the granted requester drops `req_valid` mid-packet, the grant is held with no timeout. Other requesters wait.
- Full: while `fifo_wfull = 1`, `fifo_wen = 0` and all ready bits are 0, so no beat is lost. Acceptance resumes in the first cycle `fifo_wfull = 0`.
- A single-beat packet (valid and last together) takes one GRANT cycle when the FIFO is not full.
- Requests from non-granted requesters during GRANT are ignored until the next IDLE.
- `fifo_wdata` is 0 in IDLE.
- Reset mid-packet: the partial packet already in the FIFO is not retracted. Packet integrity across reset is the system's responsibility.

## Timing
- Reset values:
  - State = IDLE, `grant = 0`, `rr_ptr = 0`, `busy = 0`.
  - `req_ready = 0`, `fifo_wen = 0`, `fifo_wdata = 0`.
- Arbitration latency: a valid seen in IDLE at edge N produces `grant` and `busy` after edge N. The first beat can be accepted in the cycle following edge N.
- There is one idle bubble cycle between consecutive packets: the IDLE cycle after the last beat.
- `req_ready`, `fifo_wen` and `fifo_wdata` are combinational from `grant`, `req_valid`, `req_data` and `fifo_wfull`. There is no combinational path from `req_valid` to `req_ready`.
- Throughput in GRANT: one beat per clock while the FIFO is not full.
- `fifo_wfull` is a registered FIFO output. The FIFO also self-gates writes when full, so `fifo_wen` asserted in the same cycle that `wfull` rises is safe.

## Configuration
- `FIFO_ARB_TAG_EN` defined:
  - `fifo_wdata` is `{idx, data}`, width IW+DW, where idx is the binary index of the granted requester.
  - The FIFO is instantiated with `DW = IW+DW`.
  - In IDLE, both idx and data are 0.
- Not defined: `fifo_wdata` is the payload only, width DW, with no index information.

## Test plan
- Reset, then `req_valid = 4'b0000` for 5 cycles -> `grant = 0`, `fifo_wen = 0`, `busy = 0` throughout.
- Requesters 1 and 2 valid together, each sending a 3-beat packet (data 0x11..0x13 and 0x21..0x23), with `rr_ptr = 0` after reset:
  - Requester 1 is granted first.
  - The FIFO receives 0x11, 0x12, 0x13, then one bubble, then 0x21, 0x22, 0x23.
  - `rr_ptr` ends at 3.
- All 4 requesters continuously sending single-beat packets -> grants rotate 0, 1, 2, 3, 0 with one write every 2 cycles.
- `fifo_wfull` forced high for 4 cycles mid-packet on requester 3 (beats 0xA0..0xA3):
  - `req_ready[3] = 0` and `fifo_wen = 0` during the stall.
  - No beat is duplicated or dropped; the FIFO receives 0xA0..0xA3 in order.
- Requester 0 granted, then drops valid for 3 cycles before its last beat while requester 2 is valid:
  - The grant stays on 0.
  - Requester 2 is granted only after requester 0's last beat, at the following IDLE.
- With `FIFO_ARB_TAG_EN`, NREQ=4, DW=8: a beat 0x5C from requester 2 -> `fifo_wdata = 10'h25C`.
  - `rst` asserted mid-packet -> `grant = 0` and `rr_ptr = 0` after the next edge.
